// File: rtl/bsg_round_robin_n_to_1_gather_pkg.sv
// Shared definitions for the strict round-robin N-to-1 gather.
// Optional source tag storage is controlled by BSG_RR_N_TO_1_TAG_EN.
package bsg_rr_gather_pkg;

    // Depth of the output decoupling buffer. The FIFO uses 1-bit
    // read/write pointers, so it is built for exactly two entries.
    localparam int rr_gather_buf_els_gp = 2;

    // Pointer width for n channels. It is at least one bit, so a
    // 1-channel build still produces a legal vector.
    function automatic int rr_gather_ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_round_robin_n_to_1_gather_if.sv
// Handshake bundle for bsg_round_robin_n_to_1_gather.
// Signal names are seen from the gather block: *_i enters it, *_o leaves it.
// tag_o exists only when BSG_RR_N_TO_1_TAG_EN is defined.
interface bsg_round_robin_n_to_1_gather_if #(
    parameter int num_in_p = 32,
    parameter int width_p  = 128
);
    import bsg_rr_gather_pkg::*;

    localparam int ptr_width_lp = rr_gather_ptr_width(num_in_p);

    logic [num_in_p-1:0]         valid_i;
    logic [num_in_p*width_p-1:0] data_i;
    logic [num_in_p-1:0]         ready_o;
    logic                        valid_o;
    logic [width_p-1:0]          data_o;
    logic                        ready_i;
`ifdef BSG_RR_N_TO_1_TAG_EN
    logic [ptr_width_lp-1:0]     tag_o;

    // The gather block itself.
    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, tag_o
    );

    // The producers and the consumer around the gather block.
    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, tag_o
    );
`else
    // The gather block itself.
    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o
    );

    // The producers and the consumer around the gather block.
    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o
    );
`endif

endinterface

// File: rtl/bsg_round_robin_n_to_1_gather_fifo2.sv
// Two-entry ready/valid FIFO with an asynchronous reset.
// o_ready depends only on the fill level, never on i_ready. A full
// buffer therefore refuses input even when a dequeue happens in the
// same cycle. This keeps the upstream ready free of any path from the
// downstream ready.
module bsg_rr_gather_fifo2
    import bsg_rr_gather_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic               i_valid,
    input  logic [width_p-1:0] i_data,
    output logic               o_ready,

    output logic               o_valid,
    output logic [width_p-1:0] o_data,
    input  logic               i_ready
);

    logic [width_p-1:0] r_mem [rr_gather_buf_els_gp];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_cnt;

    logic               w_enq;
    logic               w_deq;

    assign o_ready = (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rptr];

    assign w_enq   = i_valid & o_ready;
    assign w_deq   = o_valid & i_ready;

    // Storage, pointers and fill count. Storage is also cleared so that
    // the head entry, and any tag inside it, reads 0 after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
            for (int i = 0; i < rr_gather_buf_els_gp; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_deq) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

endmodule

// File: rtl/bsg_round_robin_n_to_1_gather.sv
// Strict round-robin N-to-1 gather. Only the channel selected by the
// pointer can be accepted. The pointer moves on by one per accepted
// word and wraps at num_in_p, including non-power-of-2 counts.
// Accepted words pass through a 2-entry buffer. The output is therefore
// registered, and ready_o does not depend on ready_i.
// Defining BSG_RR_N_TO_1_TAG_EN stores the source channel with each
// word and reports it on tag_o.
module bsg_round_robin_n_to_1_gather
    import bsg_rr_gather_pkg::*;
#(
    parameter int num_in_p = 32,
    parameter int width_p  = 128
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    bsg_round_robin_n_to_1_gather_if.slave io
);

    localparam int ptr_width_lp = rr_gather_ptr_width(num_in_p);
`ifdef BSG_RR_N_TO_1_TAG_EN
    localparam int entry_w_lp   = width_p + ptr_width_lp;
`else
    localparam int entry_w_lp   = width_p;
`endif

    logic [ptr_width_lp-1:0] r_ptr;

    logic [width_p-1:0]      w_ch_data [num_in_p];
    logic [width_p-1:0]      w_sel_data;
    logic                    w_sel_valid;
    logic                    w_buf_ready;
    logic                    w_accept;
    logic [entry_w_lp-1:0]   w_enq_entry;
    logic [entry_w_lp-1:0]   w_head_entry;

    // Split the flat data bus into channel slices so the pointer can
    // select one of them directly.
    for (genvar k = 0; k < num_in_p; k++) begin : g_ch
        assign w_ch_data[k] = io.data_i[k*width_p +: width_p];
        // Only the pointed-at channel is ever offered ready. This gives
        // a one-hot vector, or all zeros when the buffer is full or
        // reset is asserted.
        assign io.ready_o[k] = (r_ptr == ptr_width_lp'(k)) & w_buf_ready & ~reset_i;
    end

    assign w_sel_data  = w_ch_data[r_ptr];
    assign w_sel_valid = io.valid_i[r_ptr] & ~reset_i;
    assign w_accept    = w_sel_valid & w_buf_ready;

`ifdef BSG_RR_N_TO_1_TAG_EN
    assign w_enq_entry = {r_ptr, w_sel_data};
    assign io.tag_o    = w_head_entry[width_p +: ptr_width_lp];
`else
    assign w_enq_entry = w_sel_data;
`endif
    assign io.data_o   = w_head_entry[width_p-1:0];

    // Pointer advances on every accepted word and wraps explicitly at
    // num_in_p-1, so values >= num_in_p are never produced.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (r_ptr == ptr_width_lp'(num_in_p - 1)) ? '0
                                                            : r_ptr + ptr_width_lp'(1);
        end
    end

    bsg_rr_gather_fifo2 #(
        .width_p (entry_w_lp)
    ) u_buf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_valid (w_sel_valid),
        .i_data  (w_enq_entry),
        .o_ready (w_buf_ready),
        .o_valid (io.valid_o),
        .o_data  (w_head_entry),
        .i_ready (io.ready_i)
    );

endmodule

// File: tb/tb_bsg_round_robin_n_to_1_gather.sv
// Bench for the round-robin gather, using 5 channels so that the
// non-power-of-2 wrap is exercised throughout.
// Reference model: a word queue plus a "next channel" counter, updated
// from the accept/dequeue rules once per clock.
module tb_bsg_round_robin_n_to_1_gather;
    import bsg_rr_gather_pkg::*;

    localparam int N = 5;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bsg_round_robin_n_to_1_gather_if #(.num_in_p(N), .width_p(W)) bus ();

    bsg_round_robin_n_to_1_gather #(.num_in_p(N), .width_p(W)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .io      (bus)
    );

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] ch_dat [N];
    int         mp;        // model: channel expected next
    int         q[$];      // model: buffered words, {tag, data}
    int         obs[$];    // words seen leaving the DUT
    int         acc_obs;   // accepts seen at the input side

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock. Inputs must already be set; this starts at posedge+1
    // and returns at the next posedge+1.
    task automatic cycle();
        logic [N-1:0] e_rdy;
        logic [N-1:0] r1;
        bit           acc;
        bit           deq;
        for (int k = 0; k < N; k++) bus.data_i[k*W +: W] = ch_dat[k];
        if (rst) begin
            q.delete();
            mp = 0;
        end
        @(negedge clk);
        chk("valid_o", 32'(bus.valid_o), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("data_o", 32'(bus.data_o), q[0] & 32'hff);
`ifdef BSG_RR_N_TO_1_TAG_EN
            chk("tag_o", 32'(bus.tag_o), q[0] >> 8);
`endif
        end
        e_rdy = '0;
        if (!rst && q.size() < 2) e_rdy[mp] = 1'b1;
        chk("ready_o", 32'(bus.ready_o), 32'(e_rdy));
        chk("ready_onehot", 32'($countones(bus.ready_o) <= 1), 32'd1);
        // ready_o must not move when only ready_i changes.
        r1 = bus.ready_o;
        bus.ready_i = ~bus.ready_i;
        #1;
        chk("ready_comb", 32'(bus.ready_o), 32'(r1));
        bus.ready_i = ~bus.ready_i;
        #1;
        if (bus.valid_o && bus.ready_i) obs.push_back(int'(bus.data_o));
        if (|(bus.ready_o & bus.valid_i)) acc_obs++;
        acc = !rst && q.size() < 2 && bus.valid_i[mp];
        deq = q.size() != 0 && bus.ready_i;
        @(posedge clk);
        if (rst) begin
            q.delete();
            mp = 0;
        end else begin
            if (deq) void'(q.pop_front());
            if (acc) begin
                q.push_back((mp << 8) | int'(ch_dat[mp]));
                mp = (mp + 1) % N;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.valid_i = '0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_i = '0;
        bus.ready_i = 1'b0;
        bus.data_i  = '0;
        for (int k = 0; k < N; k++) ch_dat[k] = 8'(8'h10 + k);
        mp = 0;
        acc_obs = 0;
        #1;
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_ready", 32'(bus.ready_o), 32'd0);
        repeat (2) cycle();
        rst = 1'b0;

        // Basic order: all channels valid, no backpressure, one word per cycle.
        bus.valid_i = '1;
        bus.ready_i = 1'b1;
        obs.delete();
        repeat (13) cycle();
        chk("basic_cnt", 32'(obs.size()), 32'd12);
        for (int i = 0; i < 12; i++) chk("basic_seq", 32'(obs[i]), 32'(8'h10 + (i % N)));

        // Strict stall: the pointer sits on channel 1, and all other channels are valid.
        do_reset();
        bus.ready_i = 1'b1;
        bus.valid_i = 5'b00001;
        cycle();
        bus.valid_i = 5'b11101;
        acc_obs = 0;
        repeat (5) cycle();
        chk("stall_acc", 32'(acc_obs), 32'd0);
        chk("stall_rdy", 32'(bus.ready_o), 32'(5'b00010));
        bus.valid_i = 5'b11111;
        cycle();
        chk("stall_go_acc", 32'(acc_obs), 32'd1);
        chk("stall_go_rdy", 32'(bus.ready_o), 32'(5'b00100));

        // Backpressure: two accepts fill the buffer, then the block stalls.
        do_reset();
        bus.ready_i = 1'b0;
        bus.valid_i = '1;
        acc_obs = 0;
        repeat (5) cycle();
        chk("bp_acc", 32'(acc_obs), 32'd2);
        chk("bp_rdy", 32'(bus.ready_o), 32'd0);
        chk("bp_valid", 32'(bus.valid_o), 32'd1);
        chk("bp_data", 32'(bus.data_o), 32'h10);
        obs.delete();
        bus.ready_i = 1'b1;
        repeat (3) cycle();
        chk("bp_drain_cnt", 32'(obs.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("bp_drain_seq", 32'(obs[i]), 32'(8'h10 + i));

        // Async reset with two words buffered and the pointer on channel 3.
        do_reset();
        bus.ready_i = 1'b0;
        bus.valid_i = '1;
        repeat (3) cycle();
        bus.ready_i = 1'b1;
        bus.valid_i = '0;
        cycle();
        bus.ready_i = 1'b0;
        bus.valid_i = '1;
        cycle();
        chk("pre_arst_valid", 32'(bus.valid_o), 32'd1);
        chk("pre_arst_rdy", 32'(bus.ready_o), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.valid_o), 32'd0);
        chk("arst_rdy", 32'(bus.ready_o), 32'd0);
        cycle();
        rst = 1'b0;
        ch_dat[0] = 8'hA0;
        bus.ready_i = 1'b1;
        obs.delete();
        repeat (3) cycle();
        chk("arst_cnt", 32'(obs.size()), 32'd2);
        chk("arst_first", 32'(obs[0]), 32'hA0);
        ch_dat[0] = 8'h10;

        // Random valid/ready traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            bus.valid_i = N'($urandom);
            bus.ready_i = 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++) ch_dat[k] = 8'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
